// File: rtl/aes_128_batch_sched_if.sv
// Purpose : requester, core and response signal bundle for the AES-128 batch scheduler.
// Latency : none; carries wires only.
// Backpressure: req_valid/req_ready handshake toward requesters; core_idle refuses core_in_en; responses have none.
// Ports   : slave = scheduler side, master = requesters + core side (the testbench drives master).
interface aes_128_batch_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req_valid;
    logic [128*NREQ-1:0]  req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 core_in_en;
    logic [127:0]         core_data;
    logic                 core_idle;
    logic                 core_out_en;
    logic [127:0]         core_out_data;
    logic                 core_kill;
    logic [NREQ-1:0]      resp_valid;
    logic [127:0]         resp_data;
    logic                 err_wdog;

    modport slave (
        input  req_valid, req_data, core_idle, core_out_en, core_out_data,
        output req_ready, core_in_en, core_data, core_kill, resp_valid, resp_data, err_wdog
    );

    modport master (
        output req_valid, req_data, core_idle, core_out_en, core_out_data,
        input  req_ready, core_in_en, core_data, core_kill, resp_valid, resp_data, err_wdog
    );
endinterface

// File: rtl/aes_128_batch_sched.sv
// Purpose : round-robin batches of 1..3 blocks from NREQ requesters into one AES-128 core, routes results back by tag.
// Latency : grant/core_in_en combinational in the grant cycle; resp_valid one cycle after core_out_en.
// Backpressure: req_ready only while issuing and core_idle is low; responses cannot be stalled.
// Ports   : clk, rst_n (async active-low), kill (sync clear, also drives core_kill); bus = slave modport of
//           aes_128_batch_sched_if (requests, core strobe/data, core results, responses, err_wdog).
module aes_128_batch_sched #(
    parameter int NREQ = 4,
    parameter int WDOG = 63
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  kill,
    aes_128_batch_sched_if.slave  bus
);
    localparam int          IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [5:0]  WDOG_LIM = 6'(WDOG);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RECOVER} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [1:0]      bcnt_q, bcnt_d;
    logic [IW-1:0]   tag_q [3];
    logic [IW-1:0]   tag_d [3];
    logic [1:0]      wr_q, wr_d, rd_q, rd_d, fcnt_q, fcnt_d;
    logic [5:0]      wdog_q, wdog_d;
    logic            rec_q, rec_d;
    logic [NREQ-1:0] resp_valid_q, resp_valid_d;
    logic [127:0]    resp_data_q, resp_data_d;

    logic            any_vld;
    logic [IW-1:0]   gidx;
    logic            grant, pop, fire;

    // First valid requester at or after rr_q, wrapping modulo NREQ.
    always_comb begin
        int idx;
        idx     = 0;
        any_vld = 1'b0;
        gidx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any_vld && bus.req_valid[idx]) begin
                any_vld = 1'b1;
                gidx    = IW'(idx);
            end
        end
    end

    assign grant = (state_q == ISSUE) && any_vld && !bus.core_idle && !kill && (bcnt_q != 2'd3);
    // A result with no tag outstanding (late result after flush/reset) is dropped here.
    assign pop   = bus.core_out_en && (fcnt_q != 2'd0) && !kill;
    // wdog_q counts cycles since the last grant minus one, so +1 reaching the limit is exactly WDOG cycles.
    assign fire  = (state_q == WAIT) && (fcnt_q != 2'd0) && !bus.core_out_en && !kill &&
                   ((wdog_q + 6'd1) == WDOG_LIM);

    always_comb begin
        bus.req_ready = '0;
        bus.core_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant && (gidx == IW'(i))) begin
                bus.req_ready[i] = 1'b1;
                bus.core_data    = bus.req_data[128*i +: 128];
            end
        end
    end

    assign bus.core_in_en = grant;
    assign bus.core_kill  = kill | fire;
    assign bus.err_wdog   = fire;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        bcnt_d       = bcnt_q;
        tag_d        = tag_q;
        wr_d         = wr_q;
        rd_d         = rd_q;
        fcnt_d       = fcnt_q;
        wdog_d       = wdog_q;
        rec_d        = rec_q;
        resp_valid_d = '0;
        resp_data_d  = '0;

        if (grant) begin
            tag_d[wr_q] = gidx;
            wr_d        = (wr_q == 2'd2) ? 2'd0 : wr_q + 2'd1;
            rr_d        = (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
            bcnt_d      = bcnt_q + 2'd1;
        end

        if (pop) begin
            for (int i = 0; i < NREQ; i++) begin
                if (tag_q[rd_q] == IW'(i)) resp_valid_d[i] = 1'b1;
            end
            resp_data_d = bus.core_out_data;
            rd_d        = (rd_q == 2'd2) ? 2'd0 : rd_q + 2'd1;
        end

        case ({grant, pop})
            2'b10:   fcnt_d = fcnt_q + 2'd1;
            2'b01:   fcnt_d = fcnt_q - 2'd1;
            default: fcnt_d = fcnt_q;
        endcase

        if (grant || bus.core_out_en)
            wdog_d = '0;
        else if ((state_q == ISSUE) || (state_q == WAIT))
            wdog_d = wdog_q + 6'd1;

        case (state_q)
            IDLE: begin
                if ((|bus.req_valid) && !bus.core_idle) begin
                    state_d = ISSUE;
                    bcnt_d  = '0;
                end
            end
            ISSUE: begin
                // A gap (nothing grantable) or the third block closes the batch.
                if (!grant || (bcnt_q == 2'd2)) state_d = WAIT;
            end
            WAIT: begin
                if (fire) begin
                    state_d = RECOVER;
                    rec_d   = 1'b0;
                    wr_d    = '0;
                    rd_d    = '0;
                    fcnt_d  = '0;
                end else if ((fcnt_q == 2'd0) && !bus.core_idle) begin
                    state_d = IDLE;
                end
            end
            RECOVER: begin
                if (rec_q) state_d = IDLE;
                else       rec_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (kill) begin
            state_d      = IDLE;
            rr_d         = '0;
            bcnt_d       = '0;
            wr_d         = '0;
            rd_d         = '0;
            fcnt_d       = '0;
            wdog_d       = '0;
            rec_d        = 1'b0;
            resp_valid_d = '0;
            resp_data_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_q         <= '0;
            bcnt_q       <= '0;
            for (int i = 0; i < 3; i++) tag_q[i] <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
            fcnt_q       <= '0;
            wdog_q       <= '0;
            rec_q        <= 1'b0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            bcnt_q       <= bcnt_d;
            tag_q        <= tag_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            fcnt_q       <= fcnt_d;
            wdog_q       <= wdog_d;
            rec_q        <= rec_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end
endmodule

// File: tb/tb_aes_128_batch_sched.sv
// Purpose : self-checking bench for aes_128_batch_sched with a 4-cycle stub core and a result scoreboard.
// Latency : stub core returns each block 4 cycles after core_in_en.
// Backpressure: requesters hold req_valid as scripted; the stub core never stalls.
module tb_aes_128_batch_sched;
    localparam int NREQ = 4;
    localparam int WDOG = 63;

    logic clk = 1'b0;
    logic rst_n;
    logic kill;
    always #5 clk = ~clk;

    aes_128_batch_sched_if #(.NREQ(NREQ)) bus ();

    aes_128_batch_sched #(.NREQ(NREQ), .WDOG(WDOG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kill  (kill),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stand-in for AES: any fixed bijection is enough to tie a result to its block.
    function automatic logic [127:0] core_fn(input logic [127:0] x);
        return {x[63:0], x[127:64]} ^ 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    endfunction

    // ---------------- stub core: fixed 4-cycle latency, ignores core_kill ----------------
    bit           drop = 1'b0;
    logic         pipe_en [4];
    logic [127:0] pipe_dat [4];
    initial begin
        logic         s_en;
        logic [127:0] s_dat;
        for (int i = 0; i < 4; i++) begin pipe_en[i] = 1'b0; pipe_dat[i] = '0; end
        bus.core_out_en   = 1'b0;
        bus.core_out_data = '0;
        forever begin
            @(negedge clk);
            s_en  = bus.core_in_en;
            s_dat = bus.core_data;
            @(posedge clk);
            #1;
            for (int i = 3; i > 0; i--) begin pipe_en[i] = pipe_en[i-1]; pipe_dat[i] = pipe_dat[i-1]; end
            pipe_en[0]        = s_en;
            pipe_dat[0]       = s_dat;
            bus.core_out_en   = pipe_en[3] && !drop;
            bus.core_out_data = core_fn(pipe_dat[3]);
        end
    end

    // ---------------- scoreboard / grant model ----------------
    int           exp_owner_q [$];
    logic [127:0] exp_dat_q [$];
    int           rr_exp    = 0;
    int           grant_cnt = 0;
    int           resp_cnt  = 0;
    initial begin
        int              e, o, j;
        logic [127:0]    d;
        logic [NREQ-1:0] oh;
        forever begin
            @(negedge clk);
            if (bus.core_idle) chk("in_en_vs_core_idle", 128'(bus.core_in_en), 128'(0));
            if (bus.resp_valid != '0) begin
                resp_cnt++;
                if (exp_owner_q.size() == 0) begin
                    chk("resp_unexpected", 128'(bus.resp_valid), 128'(0));
                end else begin
                    o  = exp_owner_q.pop_front();
                    d  = exp_dat_q.pop_front();
                    oh = '0;
                    oh[o] = 1'b1;
                    chk("resp_owner", 128'(bus.resp_valid), 128'(oh));
                    chk("resp_data", bus.resp_data, d);
                end
            end
            if ((bus.req_ready != '0) || bus.core_in_en) begin
                e = -1;
                for (int k = 0; k < NREQ; k++) begin
                    j = (rr_exp + k) % NREQ;
                    if (e < 0 && bus.req_valid[j]) e = j;
                end
                oh = '0;
                if (e >= 0) oh[e] = 1'b1;
                chk("grant_onehot", 128'(bus.req_ready), 128'(oh));
                chk("grant_in_en", 128'(bus.core_in_en), 128'(1));
                if (e >= 0) begin
                    chk("core_data", bus.core_data, bus.req_data[128*e +: 128]);
                    exp_owner_q.push_back(e);
                    exp_dat_q.push_back(core_fn(bus.req_data[128*e +: 128]));
                    rr_exp = (e + 1) % NREQ;
                    grant_cnt++;
                end
            end
            if (!rst_n || kill) begin
                exp_owner_q.delete();
                exp_dat_q.delete();
                rr_exp = 0;
            end else if (bus.err_wdog) begin
                exp_owner_q.delete();
                exp_dat_q.delete();
            end
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [NREQ-1:0] vld;
        logic            idle;
        logic [NREQ-1:0] rdy;
        logic [NREQ-1:0] resp;
    } vec_t;
    localparam int NV = 38;
    vec_t tbl [NV];

    initial begin
        int ngr, last, got, ecyc, gcyc, r0, g0;

        // Rows are consecutive cycles starting from IDLE right after reset.
        for (int i = 0; i < NV; i++) tbl[i] = '{vld: '0, idle: 1'b0, rdy: '0, resp: '0};
        for (int i = 0; i <= 12; i++) tbl[i].vld = 4'b1111;       // full load: 0,1,2 then 3,0,1
        tbl[1].rdy  = 4'b0001; tbl[2].rdy  = 4'b0010; tbl[3].rdy  = 4'b0100;
        tbl[6].resp = 4'b0001; tbl[7].resp = 4'b0010; tbl[8].resp = 4'b0100;
        tbl[10].rdy = 4'b1000; tbl[11].rdy = 4'b0001; tbl[12].rdy = 4'b0010;
        tbl[15].resp = 4'b1000; tbl[16].resp = 4'b0001; tbl[17].resp = 4'b0010;
        tbl[19].vld = 4'b0100; tbl[20].vld = 4'b0100;             // lone requester 2
        tbl[20].rdy = 4'b0100; tbl[25].resp = 4'b0100;
        for (int i = 26; i <= 29; i++) begin tbl[i].vld = 4'b0001; tbl[i].idle = 1'b1; end
        tbl[30].vld = 4'b0001; tbl[31].vld = 4'b0001;             // core_idle drops, grant wraps to 0
        tbl[31].rdy = 4'b0001; tbl[36].resp = 4'b0001;

        rst_n = 1'b0;
        kill  = 1'b0;
        bus.req_valid = 4'b1111;
        bus.core_idle = 1'b0;
        for (int i = 0; i < NREQ; i++) bus.req_data[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready",  128'(bus.req_ready),  128'(0));
        chk("rst_core_in_en", 128'(bus.core_in_en), 128'(0));
        chk("rst_resp_valid", 128'(bus.resp_valid), 128'(0));
        chk("rst_err_wdog",   128'(bus.err_wdog),   128'(0));
        chk("rst_core_data",  bus.core_data,        128'(0));
        chk("rst_resp_data",  bus.resp_data,        128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.req_valid = '0;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            bus.req_valid = tbl[i].vld;
            bus.core_idle = tbl[i].idle;
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", i), 128'(bus.req_ready),  128'(tbl[i].rdy));
            chk($sformatf("tbl%0d_resp", i),  128'(bus.resp_valid), 128'(tbl[i].resp));
        end

        // Watchdog: 2-block batch whose results never come back.
        r0 = resp_cnt;
        drop = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 4'b0011;
        ngr = 0; last = 0;
        for (int k = 0; k < 20 && ngr < 2; k++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin ngr++; last = cyc; end
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        chk("wdog_grants", 128'(ngr), 128'(2));
        got = 0; ecyc = 0;
        for (int k = 0; k < WDOG + 20 && got == 0; k++) begin
            @(negedge clk);
            if (bus.err_wdog) begin
                got = 1; ecyc = cyc;
                chk("wdog_core_kill", 128'(bus.core_kill), 128'(1));
            end
        end
        chk("wdog_seen", 128'(got), 128'(1));
        chk("wdog_delay", 128'(ecyc - last), 128'(WDOG));
        @(posedge clk); #1;
        drop = 1'b0;
        bus.req_valid = 4'b0001;
        @(negedge clk);
        chk("wdog_pulse_width", 128'(bus.err_wdog), 128'(0));
        gcyc = 0;
        for (int k = 0; k < 10 && gcyc == 0; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.req_ready != '0) gcyc = cyc;
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        chk("recover_to_grant", 128'(gcyc - ecyc), 128'(4));
        chk("wdog_no_resp", 128'(resp_cnt - r0), 128'(0));
        repeat (12) @(posedge clk);

        // Kill on the second ISSUE cycle; the in-flight result must be dropped.
        #1;
        bus.req_valid = 4'b1111;
        @(negedge clk);
        chk("kill_idle_ready", 128'(bus.req_ready), 128'(0));
        @(negedge clk);
        chk("kill_first_grant", 128'(bus.req_ready), 128'(4'b0010));
        @(posedge clk); #1;
        kill = 1'b1;
        @(negedge clk);
        chk("kill_core_kill", 128'(bus.core_kill), 128'(1));
        chk("kill_ready_gated", 128'(bus.req_ready), 128'(0));
        @(posedge clk); #1;
        kill = 1'b0;
        bus.req_valid = '0;
        @(negedge clk);
        chk("kill_after_ready",  128'(bus.req_ready),  128'(0));
        chk("kill_after_in_en",  128'(bus.core_in_en), 128'(0));
        chk("kill_after_resp",   128'(bus.resp_valid), 128'(0));
        chk("kill_after_err",    128'(bus.err_wdog),   128'(0));
        chk("kill_after_cdata",  bus.core_data,        128'(0));
        chk("kill_after_rdata",  bus.resp_data,        128'(0));
        r0 = resp_cnt;
        repeat (10) @(negedge clk);
        chk("kill_late_result_ignored", 128'(resp_cnt - r0), 128'(0));

        // Random traffic with occasional core_idle.
        r0 = resp_cnt;
        g0 = grant_cnt;
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk); #1;
            bus.req_valid = NREQ'($urandom_range(0, 15));
            bus.core_idle = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < NREQ; i++) bus.req_data[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        bus.core_idle = 1'b0;
        repeat (20) @(negedge clk);
        chk("rand_queue_drained", 128'(exp_owner_q.size()), 128'(0));
        chk("rand_resp_per_grant", 128'(resp_cnt - r0), 128'(grant_cnt - g0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/aes_128_batch_sched.md
AES_128_BATCH_SCHED -- requirements
Module: aes_128_batch_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning the number of requesters sharing one 4-cycle AES-128 core (2..8).
REQ-002 SHALL have parameter WDOG, default 63, meaning the cycle limit from the last issued block to its result.
REQ-003 clk  in  1  single clock; all flops on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 kill  in  1  synchronous clear; same effect as reset; also forwarded to the core.
REQ-006 req_valid  in  NREQ  per-requester block pending.
REQ-007 req_data  in  128*NREQ  plaintext blocks; requester i at bits [128*i+127:128*i].
REQ-008 req_ready  out  NREQ  one-hot accept; a transfer occurs when valid and ready are both high.
REQ-009 core_in_en  out  1  block strobe to the core.
REQ-010 core_data  out  128  block to the core; valid when core_in_en is high.
REQ-011 core_idle  in  1  core busy with a batch; in_en is refused while it is high.
REQ-012 core_out_en  in  1  core result strobe.
REQ-013 core_out_data  in  128  core result.
REQ-014 resp_valid  out  NREQ  one-hot result pulse to the owning requester; no backpressure.
REQ-015 resp_data  out  128  result; valid while any resp_valid bit is high.
REQ-016 err_wdog  out  1  one-cycle pulse when the watchdog expires.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, RECOVER.
REQ-018 IDLE->ISSUE SHALL occur when any req_valid is high and core_idle is low.
REQ-019 In ISSUE, each cycle SHALL grant by round robin the first valid requester at or after rr_ptr (modulo NREQ).
REQ-020 A grant SHALL drive req_ready for that requester and core_in_en, with core_data equal to that requester's req_data, all combinationally in the same cycle.
REQ-021 A batch SHALL hold 1..3 blocks issued on consecutive cycles with no gaps.
REQ-022 ISSUE SHALL move to WAIT after the third grant, or at the first cycle with no valid requester; that cycle issues nothing.
REQ-023 After each grant, rr_ptr SHALL become the granted index +1, wrapping NREQ-1 -> 0.
REQ-024 The same requester MAY be granted more than once within a batch.
REQ-025 Each grant SHALL push the requester index into a 3-entry tag FIFO.
REQ-026 On each core_out_en, the FIFO SHALL pop, resp_valid[tag] SHALL go high registered one cycle later, and resp_data SHALL equal core_out_data. Results return in issue order.
REQ-027 WAIT->IDLE SHALL occur when the returned count equals the issued count and core_idle is low.
REQ-028 If core_idle is still high at that point, the block SHALL stay in WAIT with no new issue.
REQ-029 core_in_en SHALL never be high while core_idle is high, nor in WAIT or RECOVER.
REQ-030 The watchdog SHALL be a 6-bit counter cleared on every grant and on every core_out_en, incrementing in WAIT.
REQ-031 When the watchdog count reaches WDOG with results outstanding, err_wdog SHALL pulse, kill SHALL be forwarded to the core as core_kill for 1 cycle, the FIFO SHALL be flushed, and the FSM SHALL go to RECOVER.
REQ-032 RECOVER->IDLE SHALL occur after 2 cycles; lost results produce no resp_valid.
REQ-033 A core_out_en with an empty FIFO SHALL be ignored and SHALL NOT generate resp_valid.
REQ-034 A grant and a core_out_en in the same cycle SHALL both take effect; the FIFO never exceeds 3 entries.

Reset
REQ-035 On rst_n low or kill high, the following SHALL reset: FSM to IDLE, rr_ptr 0, FIFO empty, counters 0; req_ready, core_in_en, resp_valid and err_wdog 0; core_data and resp_data 0.
REQ-036 Reset mid-batch SHALL discard all outstanding tags; results arriving after reset SHALL be ignored per REQ-033.

Verification
REQ-037 req_valid=4'b1111 held, core model ideal -> grants 0,1,2 on 3 consecutive cycles; next batch grants 3,0,1; resp_valid order is 0,1,2.
REQ-038 Only req_valid[2] high for 1 cycle -> 1-block batch; WAIT; one resp_valid[2] pulse; returns to IDLE.
REQ-039 core_idle forced high while req_valid=4'b0001 -> core_in_en stays 0 until core_idle drops.
REQ-040 Core never returns core_out_en after a 2-block batch -> err_wdog pulses WDOG cycles after the last grant, then RECOVER, then IDLE; no resp_valid.
REQ-041 kill asserted on the 2nd ISSUE cycle -> all outputs 0 next cycle; late core_out_en ignored.
REQ-042 Random valid patterns for 10k cycles -> every accepted block yields exactly one resp_valid to its owner, in order, and the core_in_en/core_idle overlap check holds.
